// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU and the program loader.
// The CPU has priority, a fairness counter forces loader slots, and a lock mode gives the loader exclusive use.
module mem_arbiter #(
  parameter int FAIR_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_adr,
  input  logic [15:0] i_cpu_wdata,
  output logic [15:0] o_cpu_rdata,
  output logic        o_cpu_hold,
  input  logic        i_ldr_req,
  input  logic        i_ldr_we,
  input  logic [15:0] i_ldr_adr,
  input  logic [15:0] i_ldr_wdata,
  input  logic        i_ldr_lock,
  output logic        o_ldr_ack,
  output logic [15:0] o_ldr_rdata,
  output logic [15:0] o_mem_adr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [15:0] i_mem_rdata,
  output logic [7:0]  o_status
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CPU  = 2'b01,
    S_LDR  = 2'b10
  } state_t;

  localparam logic [3:0] LIMIT = 4'(FAIR_LIMIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_fair_cnt;
  logic [15:0] r_ldr_rdata;
  logic        w_ldr_ack;
  logic        w_fair_hit;

  // The forced slot never repeats from LDR: the loader gets one access, then the CPU is reconsidered.
  assign w_fair_hit = i_ldr_req && (r_fair_cnt == LIMIT) && (r_state != S_LDR);
  assign w_ldr_ack  = (r_state == S_LDR) && i_ldr_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE, S_CPU, S_LDR: begin
        if (i_ldr_lock)     w_state_nxt = i_ldr_req ? S_LDR : S_IDLE;
        else if (w_fair_hit) w_state_nxt = S_LDR;
        else if (i_cpu_req)  w_state_nxt = S_CPU;
        else if (i_ldr_req)  w_state_nxt = S_LDR;
        else                 w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_fair_cnt <= 4'h0;
    else if ((r_state == S_LDR) || !i_ldr_req)
      r_fair_cnt <= 4'h0;
    else if ((r_state == S_CPU) && i_cpu_req && (r_fair_cnt != LIMIT))
      r_fair_cnt <= r_fair_cnt + 4'h1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                   r_ldr_rdata <= 16'h0000;
    else if (w_ldr_ack && !i_ldr_we) r_ldr_rdata <= i_mem_rdata;
  end

  always_comb begin
    o_mem_adr   = 16'h0000;
    o_mem_wdata = 16'h0000;
    o_mem_we    = 1'b0;
    case (r_state)
      S_CPU: begin
        o_mem_adr   = i_cpu_adr;
        o_mem_wdata = i_cpu_wdata;
        o_mem_we    = i_cpu_we & i_cpu_req;
      end
      S_LDR: begin
        o_mem_adr   = i_ldr_adr;
        o_mem_wdata = i_ldr_wdata;
        o_mem_we    = i_ldr_we & i_ldr_req;
      end
      default: ;
    endcase
  end

  assign o_cpu_rdata = i_mem_rdata;
  assign o_cpu_hold  = i_ldr_lock | (i_cpu_req & (r_state != S_CPU));
  assign o_ldr_ack   = w_ldr_ack;
  assign o_ldr_rdata = r_ldr_rdata;
  assign o_status    = {r_state, i_ldr_lock, o_cpu_hold, r_fair_cnt};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: ownership model checked every cycle plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
  logic [15:0] cpu_adr = 0, cpu_wdata = 0, ldr_adr = 0, ldr_wdata = 0;
  logic [15:0] cpu_rdata, ldr_rdata, mem_adr, mem_wdata, mem_rdata;
  logic        cpu_hold, ldr_ack, mem_we;
  logic [7:0]  status;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FAIR_LIMIT(FL)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_adr(cpu_adr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_hold(cpu_hold),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_adr(ldr_adr), .i_ldr_wdata(ldr_wdata),
    .i_ldr_lock(ldr_lock), .o_ldr_ack(ldr_ack), .o_ldr_rdata(ldr_rdata),
    .o_mem_adr(mem_adr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata), .o_status(status)
  );

  // Memory: written words are remembered, others read a fixed pattern (0x0010 holds E1C2).
  logic [15:0] mem [256];
  bit          written [256];
  assign mem_rdata = written[mem_adr[7:0]] ? mem[mem_adr[7:0]] :
                     (mem_adr == 16'h0010) ? 16'hE1C2 : {8'hD0, mem_adr[7:0]};
  always @(posedge clk)
    if (mem_we) begin
      mem[mem_adr[7:0]]     <= mem_wdata;
      written[mem_adr[7:0]] <= 1'b1;
    end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port (0 none, 1 cpu, 2 loader), how long the loader has waited, last loader read.
  int          m_own;
  int          m_fair;
  logic [15:0] m_lrd;

  function automatic int pick_owner(int own, int fair, logic c, logic l, logic lk);
    if (lk)                 return l ? 2 : 0;
    if (own == 2 && c)      return 1;
    if (l && fair >= FL)    return 2;
    if (c)                  return 1;
    if (l)                  return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= 0; m_fair <= 0; m_lrd <= 16'h0;
    end else begin
      m_own <= pick_owner(m_own, m_fair, cpu_req, ldr_req, ldr_lock);
      if (m_own == 2 || !ldr_req)                 m_fair <= 0;
      else if (m_own == 1 && cpu_req && m_fair < FL) m_fair <= m_fair + 1;
      if (m_own == 2 && ldr_req && !ldr_we)       m_lrd <= mem_rdata;
    end
  end

  always @(negedge clk) begin
    logic        e_hold, e_ack, e_we;
    logic [15:0] e_adr, e_wd;
    e_hold = ldr_lock || (cpu_req && m_own != 1);
    e_ack  = (m_own == 2) && ldr_req;
    e_adr  = (m_own == 1) ? cpu_adr   : (m_own == 2) ? ldr_adr   : 16'h0;
    e_wd   = (m_own == 1) ? cpu_wdata : (m_own == 2) ? ldr_wdata : 16'h0;
    e_we   = (m_own == 1) ? (cpu_we && cpu_req) : (m_own == 2) ? (ldr_we && ldr_req) : 1'b0;
    chk("m_hold",   {15'h0, cpu_hold}, {15'h0, e_hold});
    chk("m_ack",    {15'h0, ldr_ack},  {15'h0, e_ack});
    chk("m_adr",    mem_adr, e_adr);
    chk("m_wdata",  mem_wdata, e_wd);
    chk("m_we",     {15'h0, mem_we}, {15'h0, e_we});
    chk("m_crdata", cpu_rdata, mem_rdata);
    chk("m_lrdata", ldr_rdata, m_lrd);
    chk("m_status", {8'h0, status}, {8'h0, 2'(m_own), ldr_lock, e_hold, 4'(m_fair)});
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  initial begin
    neg; chk("rst_status", {8'h0, status}, 16'h0000);
    chk("rst_we", {15'h0, mem_we}, 16'h0);
    cyc(2); rst_n = 1;

    // single CPU read
    cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0010;
    neg; chk("t1_hold", {15'h0, cpu_hold}, 16'h1); chk("t1_st0", {8'h0, status}, 16'h0010);
    cyc; neg;
    chk("t1_hold2", {15'h0, cpu_hold}, 16'h0); chk("t1_adr", mem_adr, 16'h0010);
    chk("t1_rd", cpu_rdata, 16'hE1C2); chk("t1_we", {15'h0, mem_we}, 16'h0);
    chk("t1_st1", {8'h0, status}, 16'h0040);
    cyc; cpu_req = 0;

    // loader-only writes
    ldr_req = 1; ldr_we = 1; ldr_adr = 16'h0000; ldr_wdata = 16'hAAAA;
    neg; chk("t2_ack0", {15'h0, ldr_ack}, 16'h0);
    cyc; neg;
    chk("t2_ack1", {15'h0, ldr_ack}, 16'h1); chk("t2_we1", {15'h0, mem_we}, 16'h1);
    chk("t2_adr1", mem_adr, 16'h0000); chk("t2_wd1", mem_wdata, 16'hAAAA);
    chk("t2_st", {8'h0, status}, 16'h0080);
    cyc; ldr_adr = 16'h0001; ldr_wdata = 16'h5555;
    neg;
    chk("t2_ack2", {15'h0, ldr_ack}, 16'h1); chk("t2_we2", {15'h0, mem_we}, 16'h1);
    chk("t2_adr2", mem_adr, 16'h0001); chk("t2_wd2", mem_wdata, 16'h5555);
    cyc; ldr_req = 0; ldr_we = 0;
    cyc(2);
    ldr_req = 1; ldr_adr = 16'h0000;
    neg; chk("t2_rack0", {15'h0, ldr_ack}, 16'h0);
    cyc; neg;
    chk("t2_rack1", {15'h0, ldr_ack}, 16'h1); chk("t2_rpass", cpu_rdata, 16'hAAAA);
    cyc; ldr_req = 0;
    neg; chk("t2_lrd", ldr_rdata, 16'hAAAA);

    // fairness: CPU streams, loader waits
    cpu_req = 1; cpu_adr = 16'h0020;
    cyc; ldr_req = 1; ldr_adr = 16'h0001;
    for (int i = 0; i <= FL; i++) begin
      neg;
      chk("t3_cpu_st", {8'h0, status}, {8'h0, 2'b01, 1'b0, 1'b0, 4'(i)});
      chk("t3_noack", {15'h0, ldr_ack}, 16'h0);
      cyc;
    end
    neg;
    chk("t3_ack", {15'h0, ldr_ack}, 16'h1); chk("t3_hold", {15'h0, cpu_hold}, 16'h1);
    chk("t3_st", {8'h0, status}, 16'h0094); chk("t3_adr", mem_adr, 16'h0001);
    cyc; ldr_req = 0;
    neg; chk("t3_back", {8'h0, status}, 16'h0040); chk("t3_lrd", ldr_rdata, 16'h5555);

    // simultaneous requests from IDLE
    cpu_req = 0;
    cyc;
    cpu_req = 1; cpu_adr = 16'h0022; ldr_req = 1; ldr_we = 0; ldr_adr = 16'h0010;
    neg; chk("t4_hold", {15'h0, cpu_hold}, 16'h1); chk("t4_st0", {8'h0, status}, 16'h0010);
    cyc; neg;
    chk("t4_cpu", {8'h0, status}, 16'h0040); chk("t4_ack0", {15'h0, ldr_ack}, 16'h0);
    cyc; cpu_req = 0;
    neg; chk("t4_st1", {8'h0, status}, 16'h0041); chk("t4_ack1", {15'h0, ldr_ack}, 16'h0);
    cyc; neg;
    chk("t4_ack2", {15'h0, ldr_ack}, 16'h1); chk("t4_st2", {8'h0, status}, 16'h0081);
    cyc; ldr_req = 0;
    neg; chk("t4_lrd", ldr_rdata, 16'hE1C2);

    // lock during CPU store burst
    cpu_req = 1; cpu_we = 1; cpu_adr = 16'h0030; cpu_wdata = 16'h1234;
    cyc; neg;
    chk("t5_we0", {15'h0, mem_we}, 16'h1); chk("t5_adr0", mem_adr, 16'h0030);
    cyc;
    cpu_adr = 16'h0031; cpu_wdata = 16'h1235;
    ldr_lock = 1; ldr_req = 1; ldr_we = 1; ldr_adr = 16'h0040; ldr_wdata = 16'hBEEF;
    neg;
    chk("t5_inflight_we", {15'h0, mem_we}, 16'h1); chk("t5_inflight_adr", mem_adr, 16'h0031);
    chk("t5_inflight_wd", mem_wdata, 16'h1235); chk("t5_hold", {15'h0, cpu_hold}, 16'h1);
    chk("t5_st0", {8'h0, status}, 16'h0070);
    cyc; neg;
    chk("t5_ack1", {15'h0, ldr_ack}, 16'h1); chk("t5_adr1", mem_adr, 16'h0040);
    chk("t5_wd1", mem_wdata, 16'hBEEF); chk("t5_st1", {8'h0, status}, 16'h00B1);
    cyc; ldr_adr = 16'h0041; ldr_wdata = 16'hBEF0;
    neg; chk("t5_ack2", {15'h0, ldr_ack}, 16'h1); chk("t5_adr2", mem_adr, 16'h0041);
    chk("t5_hold2", {15'h0, cpu_hold}, 16'h1);
    cyc; ldr_req = 0; ldr_we = 0;
    neg; chk("t5_ack3", {15'h0, ldr_ack}, 16'h0); chk("t5_we3", {15'h0, mem_we}, 16'h0);
    cyc; neg; chk("t5_idle", {8'h0, status}, 16'h0030);
    cyc; ldr_lock = 0;
    neg; chk("t5_unlock", {8'h0, status}, 16'h0010);
    cyc; neg;
    chk("t5_resume_adr", mem_adr, 16'h0031); chk("t5_resume_we", {15'h0, mem_we}, 16'h1);
    chk("t5_resume_hold", {15'h0, cpu_hold}, 16'h0);
    chk("t5_mem40", mem[8'h40], 16'hBEEF);

    // reset in the middle of a loader write
    cyc; cpu_req = 0; cpu_we = 0;
    ldr_req = 1; ldr_we = 1; ldr_adr = 16'h0050; ldr_wdata = 16'h0F0F;
    cyc; neg;
    chk("t6_pre_we", {15'h0, mem_we}, 16'h1); chk("t6_pre_ack", {15'h0, ldr_ack}, 16'h1);
    #2 rst_n = 0;
    #1;
    chk("t6_we", {15'h0, mem_we}, 16'h0); chk("t6_ack", {15'h0, ldr_ack}, 16'h0);
    chk("t6_adr", mem_adr, 16'h0000); chk("t6_wd", mem_wdata, 16'h0000);
    chk("t6_lrd", ldr_rdata, 16'h0000); chk("t6_st", {8'h0, status}, 16'h0000);
    cyc; rst_n = 1;
    neg; chk("t6_post_ack0", {15'h0, ldr_ack}, 16'h0);
    cyc; neg;
    chk("t6_post_ack1", {15'h0, ldr_ack}, 16'h1); chk("t6_post_adr", mem_adr, 16'h0050);
    cyc; ldr_req = 0; ldr_we = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
